// File: rtl/seg7_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Avalon-MM slave bus of the 7-segment scan controller.
//   avs_address   : register index (0-5 DIGn, 6 CTRL, 7 BTN)
//   avs_write     : write strobe, avs_writedata captured on the same edge
//   avs_writedata : write data
//   avs_read      : read strobe
//   avs_readdata  : read data, valid the cycle after avs_read
// Handshake: there are no wait states. A strobe that is high at a rising
// edge is a complete transfer; read data is registered and presented the
// cycle after the read strobe was sampled.
// ---------------------------------------------------------------------------
interface seg7_scan_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Six-digit multiplexed 7-segment scanner plus debounced push-buttons,
// controlled over Avalon-MM.
//   clk_clk     : system clock, rising edge
//   reset_reset : synchronous active-high reset
//   avs         : Avalon-MM slave bus (seg7_scan_ctrl_if.slave)
//   selseg      : active-high segments, bit0=a .. bit6=g, bit7=dp
//   nseldig     : active-low digit enables, at most one low
//   nbutton     : raw active-low buttons, asynchronous
//   ledbutton   : debounced pressed state (1 = pressed)
//   reset_led   : high until software first writes CTRL
//   dbg_state_o : scan FSM state (1 = SCAN, 0 = IDLE)
// All outputs are registered from next-state values, so each output
// reflects the internal state held during the same cycle.
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4,
  parameter int DEBOUNCE  = 1000000
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  seg7_scan_ctrl_if.slave        avs,
  output logic [7:0]             selseg,
  output logic [5:0]             nseldig,
  input  logic [3:0]             nbutton,
  output logic [3:0]             ledbutton,
  output logic                   reset_led,
  output logic                   dbg_state_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK_CYC);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  // Register file
  logic [7:0] dig_q [6];
  logic [7:0] dig_d [6];
  logic [1:0] ctrl_q, ctrl_d;
  logic [3:0] flag_q, flag_d;
  logic       rled_q, rled_d;
  logic [31:0] rdata_q, rdata_d;

  // Scan scheduler
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sel_q, sel_d;
  logic [5:0]       nsel_q, nsel_d;

  // Buttons
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      stable_q, stable_d;
  logic [DB_W-1:0] cnt_q [4];
  logic [DB_W-1:0] cnt_d [4];
  logic [3:0]      press;
  logic [3:0]      flag_clr;

  logic wd_unused;
  assign wd_unused = ^avs.avs_writedata[31:8];

  // Register writes and read mux (reads see pre-write values)
  always_comb begin
    dig_d    = dig_q;
    ctrl_d   = ctrl_q;
    rled_d   = rled_q;
    flag_clr = 4'b0000;
    if (avs.avs_write) begin
      if (avs.avs_address <= 3'd5) begin
        dig_d[avs.avs_address] = avs.avs_writedata[7:0];
      end else if (avs.avs_address == 3'd6) begin
        ctrl_d = avs.avs_writedata[1:0];
        rled_d = 1'b0;
      end else begin
        flag_clr = avs.avs_writedata[7:4];
      end
    end

    rdata_d = rdata_q;
    if (avs.avs_read) begin
      if (avs.avs_address <= 3'd5) begin
        rdata_d = {24'd0, dig_q[avs.avs_address]};
      end else if (avs.avs_address == 3'd6) begin
        rdata_d = {30'd0, ctrl_q};
      end else begin
        rdata_d = {24'd0, flag_q, stable_q};
      end
    end
  end

  // Debounce: count consecutive disagreeing samples, accept on the last one
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        press[i]    = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // A press accepted in the same cycle as a clearing write survives.
    flag_d = (flag_q & ~flag_clr) | press;
  end

  // Scan next state; EN/BLANK act from the cycle after the CTRL write
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        idx_d = 3'd0;
        if (ctrl_d[0]) state_d = SCAN;
      end
      default: begin
        if (!ctrl_d[0]) begin
          state_d = IDLE;
          div_d   = '0;
          idx_d   = 3'd0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    endcase

    sel_d  = 8'h00;
    nsel_d = 6'b111111;
    if (state_d == SCAN) begin
      sel_d = dig_d[idx_d];
      // Leading BLANK_CYC cycles of each slot stay dark to avoid ghosting.
      if (div_d >= BLANK_V && !ctrl_d[1]) nsel_d = ~(6'b000001 << idx_d);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < 6; i++) dig_q[i] <= 8'h00;
      ctrl_q   <= 2'b00;
      flag_q   <= 4'b0000;
      rled_q   <= 1'b1;
      rdata_q  <= 32'd0;
      state_q  <= IDLE;
      div_q    <= '0;
      idx_q    <= 3'd0;
      sel_q    <= 8'h00;
      nsel_q   <= 6'b111111;
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      stable_q <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      dig_q    <= dig_d;
      ctrl_q   <= ctrl_d;
      flag_q   <= flag_d;
      rled_q   <= rled_d;
      rdata_q  <= rdata_d;
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      nsel_q   <= nsel_d;
      sync1_q  <= ~nbutton;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign avs.avs_readdata = rdata_q;
  assign selseg           = sel_q;
  assign nseldig          = nsel_q;
  assign ledbutton        = stable_q;
  assign reset_led        = rled_q;
  assign dbg_state_o      = (state_q == SCAN);

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Bench for seg7_scan_ctrl with a small SCAN_DIV/BLANK_CYC/DEBOUNCE.
// The reference model tracks elapsed cycles since scan enable (slot and
// digit come from division), keeps a raw button-sample history and accepts a
// change once DEBOUNCE synchronized samples agree, and mirrors the registers.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int DEBOUNCE  = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] selseg;
  logic [5:0] nseldig;
  logic [3:0] nbutton;
  logic [3:0] ledbutton;
  logic       reset_led;
  logic       dbg_state;

  seg7_scan_ctrl_if avs_if ();

  seg7_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .avs        (avs_if.slave),
    .selseg     (selseg),
    .nseldig    (nseldig),
    .nbutton    (nbutton),
    .ledbutton  (ledbutton),
    .reset_led  (reset_led),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic [7:0]  m_dig [6];
  logic [1:0]  m_ctrl;
  logic [3:0]  m_flag;
  logic [3:0]  m_stable;
  logic        m_rled;
  bit          m_en;
  int          m_t;
  bit          m_valid = 0;
  logic [3:0]  m_hist[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    if (a <= 3'd5) return {24'd0, m_dig[a]};
    if (a == 3'd6) return {30'd0, m_ctrl};
    return {24'd0, m_flag, m_stable};
  endfunction

  always @(posedge clk) begin
    logic [3:0] clr;
    logic [3:0] set;
    logic       v;
    bit         agree;
    if (rst) begin
      for (int i = 0; i < 6; i++) m_dig[i] = 8'h00;
      m_ctrl = 2'b00; m_flag = 4'h0; m_stable = 4'h0; m_rled = 1'b1;
      m_en = 0; m_t = 0;
      m_hist.delete();
      for (int i = 0; i < DEBOUNCE + 1; i++) m_hist.push_back(4'h0);
      exp_q.delete();
      exp_q.push_back(32'd0);
      m_valid = 1;
    end else if (m_valid) begin
      if (avs_if.avs_read) exp_q.push_back(m_reg(avs_if.avs_address));
      clr = 4'h0;
      if (avs_if.avs_write) begin
        if (avs_if.avs_address <= 3'd5) m_dig[avs_if.avs_address] = avs_if.avs_writedata[7:0];
        else if (avs_if.avs_address == 3'd6) begin
          m_ctrl = avs_if.avs_writedata[1:0];
          m_rled = 1'b0;
        end else clr = avs_if.avs_writedata[7:4];
      end
      // Samples taken two to DEBOUNCE+1 edges ago are what the synchronizer
      // has delivered by now; all must agree and differ from the state.
      m_hist.push_back(~nbutton);
      if (m_hist.size() > DEBOUNCE + 2) void'(m_hist.pop_front());
      set = 4'h0;
      for (int i = 0; i < 4; i++) begin
        v = m_hist[0][i];
        agree = 1;
        for (int j = 1; j < DEBOUNCE; j++) if (m_hist[j][i] != v) agree = 0;
        if (agree && v != m_stable[i]) begin
          m_stable[i] = v;
          if (v) set[i] = 1'b1;
        end
      end
      m_flag = (m_flag & ~clr) | set;
      if (m_ctrl[0]) begin
        if (!m_en) begin
          m_en = 1;
          m_t = 0;
        end else m_t++;
      end else m_en = 0;
    end
  end

  // Compare process: every cycle after the first reset edge
  always @(negedge clk) begin
    int         idx;
    int         div;
    logic [5:0] e_n;
    logic [7:0] e_s;
    logic [5:0] lows;
    if (m_valid) begin
      idx = (m_t / SCAN_DIV) % 6;
      div = m_t % SCAN_DIV;
      e_s = m_en ? m_dig[idx] : 8'h00;
      e_n = 6'b111111;
      if (m_en && div >= BLANK_CYC && !m_ctrl[1]) e_n[idx] = 1'b0;
      lows = ~nseldig;
      check("selseg", {24'd0, selseg}, {24'd0, e_s});
      check("nseldig", {26'd0, nseldig}, {26'd0, e_n});
      check("nseldig_onehot", {31'd0, $countones(lows) <= 1}, 32'd1);
      check("ledbutton", {28'd0, ledbutton}, {28'd0, m_stable});
      check("reset_led", {31'd0, reset_led}, {31'd0, m_rled});
      check("dbg_state", {31'd0, dbg_state}, {31'd0, m_en});
      if (exp_q.size() > 0) check("readdata", avs_if.avs_readdata, exp_q.pop_front());
    end
  end

  // Driver tasks: called at a negedge, return at the next negedge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_if.avs_address = a; avs_if.avs_writedata = d; avs_if.avs_write = 1'b1;
    @(negedge clk);
    avs_if.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_if.avs_address = a; avs_if.avs_read = 1'b1;
    @(negedge clk);
    avs_if.avs_read = 1'b0;
    d = avs_if.avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  pats [6];
    int          hold [4];
    int          op;
    bit          reached;
    pats[0] = 8'h3F; pats[1] = 8'h06; pats[2] = 8'h5B;
    pats[3] = 8'h4F; pats[4] = 8'h66; pats[5] = 8'h6D;
    rst = 1'b1; nbutton = 4'hF;
    avs_if.avs_address = 3'd0; avs_if.avs_write = 1'b0;
    avs_if.avs_writedata = 32'd0; avs_if.avs_read = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("lit_reset_nseldig", {26'd0, nseldig}, 32'h3F);
    check("lit_reset_selseg", {24'd0, selseg}, 32'h0);
    check("lit_reset_led", {31'd0, reset_led}, 32'd1);

    // Scan bring-up
    for (int i = 0; i < 6; i++) bus_write(3'(i), {24'd0, pats[i]});
    bus_write(3'd6, 32'd1);
    check("lit_rled_drop", {31'd0, reset_led}, 32'd0);
    check("lit_slot0_dark", {26'd0, nseldig}, 32'h3F);
    check("lit_slot0_seg", {24'd0, selseg}, 32'h3F);
    idle(2);
    check("lit_slot0_lit", {26'd0, nseldig}, {26'd0, 6'b111110});
    idle(8);
    check("lit_slot1_lit", {26'd0, nseldig}, {26'd0, 6'b111101});
    check("lit_slot1_seg", {24'd0, selseg}, 32'h06);
    idle(100);

    // Forced blanking keeps the scan moving
    bus_write(3'd6, 32'd3);
    check("lit_blank", {26'd0, nseldig}, 32'h3F);
    idle(21);
    bus_write(3'd6, 32'd1);
    idle(60);

    // Glitch then a real press on button 2
    nbutton[2] = 1'b0; idle(3); nbutton[2] = 1'b1;
    idle(10);
    check("lit_glitch", {28'd0, ledbutton}, 32'h0);
    nbutton[2] = 1'b0;
    idle(5);
    check("lit_press_early", {28'd0, ledbutton}, 32'h0);
    idle(1);
    check("lit_press", {28'd0, ledbutton}, 32'h4);
    idle(4);
    bus_read(3'd7, rd);
    check("lit_btn_44", rd, 32'h44);
    nbutton[2] = 1'b1;
    idle(10);

    // Clearing write lands on the acceptance edge of a new press
    nbutton[2] = 1'b0;
    idle(5);
    bus_write(3'd7, 32'h40);
    bus_read(3'd7, rd);
    check("lit_set_wins", rd, 32'h44);
    bus_write(3'd7, 32'h40);
    bus_read(3'd7, rd);
    check("lit_flag_clear", rd, 32'h04);
    nbutton[2] = 1'b1;
    idle(10);

    // Randomized traffic and button noise
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          nbutton[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 12);
        end else hold[i]--;
      end
      op = $urandom_range(0, 9);
      avs_if.avs_address   = 3'($urandom_range(0, 7));
      avs_if.avs_writedata = $urandom;
      if (avs_if.avs_address == 3'd6) avs_if.avs_writedata[0] = ($urandom_range(0, 3) != 0);
      avs_if.avs_write = (op <= 2) || (op == 6);
      avs_if.avs_read  = (op >= 3) && (op <= 6);
      @(negedge clk);
      avs_if.avs_write = 1'b0;
      avs_if.avs_read  = 1'b0;
    end
    nbutton = 4'hF;
    idle(10);

    // Reset in the middle of slot 3
    bus_write(3'd3, 32'h4F);
    bus_write(3'd6, 32'd1);
    reached = 0;
    for (int k = 0; k < 200; k++) begin
      if (m_en && ((m_t / SCAN_DIV) % 6) == 3 && (m_t % SCAN_DIV) == 4) begin
        reached = 1;
        break;
      end
      @(negedge clk);
    end
    check("reach_slot3", {31'd0, reached}, 32'd1);
    check("lit_slot3_lit", {26'd0, nseldig}, {26'd0, 6'b110111});
    rst = 1'b1;
    @(negedge clk);
    check("lit_rst_nseldig", {26'd0, nseldig}, 32'h3F);
    check("lit_rst_selseg", {24'd0, selseg}, 32'h0);
    check("lit_rst_led", {31'd0, reset_led}, 32'd1);
    rst = 1'b0;
    bus_read(3'd3, rd);
    check("lit_dig3_cleared", rd, 32'h0);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Avalon-MM controlled scan controller for the six-digit multiplexed 7-segment display and the four push-buttons on the board. It time-shares the shared segment bus `selseg` across the six digit enables `nseldig`, one slot per digit, from six CPU-written pattern registers. It also debounces the active-low buttons, mirrors them on `ledbutton`, and latches press events for software. It sits inside the Qsys system between the Nios II data master and the display/button conduits.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot (≥ `BLANK_CYC`+2).
- `BLANK_CYC`, 4: cycles at the start of each slot with all digits off (anti-ghosting).
- `DEBOUNCE`, 1000000: consecutive stable synchronized samples required to accept a button change (≥2).
- `clk_clk`  in  1  system clock; all logic on rising edge.
- `reset_reset`  in  1  synchronous, active-high reset.
- `avs_address`  in  3  register index.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_read`  in  1  read strobe.
- `avs_readdata`  out  32  read data, valid 1 cycle after `avs_read`.
- `selseg`  out  8  active-high segments; bit0=a … bit6=g, bit7=dp.
- `nseldig`  out  6  active-low digit enables; at most one bit low.
- `nbutton`  in  4  raw active-low buttons, asynchronous.
- `ledbutton`  out  4  debounced pressed state (1 = pressed).
- `reset_led`  out  1  high until software first writes CTRL.

## Operation
- Registers:
  - 0–5 DIGn[7:0]: pattern for digit n, R/W.
  - 6 CTRL: bit0 EN (scan enable), bit1 BLANK (force all digits off), R/W.
  - 7 BTN: [3:0] debounced state (RO); [7:4] sticky press flags. Writing 1 to a flag bit clears it; writing 0 leaves it unchanged.
  - Unused bits read 0 and ignore writes.
- Reset: all DIGn=0 and CTRL=0; divider `div`=0; digit index `idx`=0; flags=0; debounce state=released. Outputs reset to `selseg`=0x00, `nseldig`=6'b111111, `ledbutton`=0, `avs_readdata`=0, `reset_led`=1.
- Scan scheduler, states IDLE and SCAN:
  - IDLE (EN=0): `div`=`idx`=0, `nseldig` all 1, `selseg`=0.
  - IDLE→SCAN when EN=1. The first slot is digit 0 with `div`=0.
  - SCAN: `div` counts 0..SCAN_DIV-1. At `div`=SCAN_DIV-1, `div`←0 and `idx`←`idx`+1; `idx` wraps 5→0.
  - SCAN→IDLE on EN=0, taking effect the next cycle (mid-slot allowed).
- Outputs in SCAN (all registered):
  - `selseg`=DIG[idx] every cycle, so a write to the active digit appears on the next cycle.
  - `nseldig[idx]`=0 only when `div`≥BLANK_CYC and BLANK=0; otherwise all 1.
  - BLANK does not stop `div` or `idx`.
- Buttons:
  - Each `~nbutton[i]` passes through a 2-FF synchronizer.
  - A per-button counter increments while the synchronized value ≠ stable state and clears when they are equal.
  - On reaching DEBOUNCE-1 the stable state takes the new value and the counter clears.
  - A released→pressed transition sets flag[i].
  - If a clearing write to flag[i] and a set of flag[i] happen in the same cycle, the set wins.
- `reset_led`: cleared by the first write to CTRL; set again only by reset.
- Reads: returns the registered value of the addressed register. Read and write in the same cycle to the same address returns the old value.

## Timing
- Slot length is exactly SCAN_DIV cycles. Full refresh is 6·SCAN_DIV cycles (≈6 ms at 50 MHz with defaults).
- Digit dark time per slot is exactly BLANK_CYC cycles. There is never an overlap of two low `nseldig` bits.
- Button latency: a steady `nbutton` edge reaches `ledbutton` and BTN[3:0] exactly 2+DEBOUNCE cycles later. A glitch shorter than DEBOUNCE samples produces no change.
- Register write takes effect on the cycle after `avs_write`. Read data appears the cycle after `avs_read`, with no wait states.
- Reset asserted mid-scan returns all outputs to their reset values on the next edge.

## Test plan
- Reset, then write DIG0..5=0x3F,0x06,0x5B,0x4F,0x66,0x6D and CTRL=1 (SCAN_DIV=8, BLANK_CYC=2):
  - `nseldig` cycles 111110→…→011111, each low for 6 of 8 cycles, with `selseg` matching the digit.
  - `reset_led` drops 1 cycle after the CTRL write.
- With scan running, write CTRL=3 → `nseldig`=111111 from the next cycle while `idx` keeps advancing. Write CTRL=1 → resumes on the correct digit.
- DEBOUNCE=4: pulse `nbutton[2]` low for 3 cycles → no change. Hold it low for 10 cycles → `ledbutton`=0100 6 cycles after the edge; BTN reads 0x44.
- Write BTN=0x40 in the same cycle a new press of button 2 is accepted → flag remains 1. A later write of 0x40 alone → BTN[7:4]=0.
- Assert reset mid-slot 3 → next cycle `nseldig`=111111, `selseg`=0, `reset_led`=1. DIG3 reads 0 after reset.
